minirisc_bus_arbiter: RTL and testbench

Round-robin arbiter and bus multiplexer for the MiniRISC data-memory bus. It shares one slave-side bus between up to NUM_MST masters using the req/grant handshake that the CPU's master interface already speaks: the CPU core, a DMA engine and the debug module. It sits between the masters and the data memory / peripheral address decoder. A grant is held for as long as its owner keeps requesting, so multi-cycle stack push/pop sequences are never split.

---
 rtl/minirisc_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_minirisc_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minirisc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// minirisc_bus_arbiter
//
// Round-robin arbiter and bus multiplexer for the MiniRISC data-memory bus.
// Up to NUM_MST masters (CPU core, DMA engine, debug module, ...) share one
// slave-side bus. A master keeps its grant for as long as it holds its request,
// so multi-cycle sequences such as stack push/pop are never split. When the
// owner releases, the next requester after the previous owner wins at the next
// edge, giving gap-free hand-over and starvation-free service.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous reset, active-low
//   m_bus_req       per-master request (level, held for the whole sequence)
//   m_bus_grant     per-master grant, registered, one-hot or zero
//   m_mst2slv_addr  per-master address      (byte slice i = master i)
//   m_mst2slv_wr    per-master write strobe
//   m_mst2slv_rd    per-master read strobe
//   m_mst2slv_data  per-master write data   (byte slice i = master i)
//   m_slv2mst_data  read data broadcast to every master
//   s_mst2slv_addr  slave address    (granted master's, else 0)
//   s_mst2slv_wr    slave write strobe
//   s_mst2slv_rd    slave read strobe
//   s_mst2slv_data  slave write data
//   s_slv2mst_data  slave read data
//   bus_busy        some grant is active
//   bus_owner       index of the granted master, 0 when idle
// -----------------------------------------------------------------------------
module minirisc_bus_arbiter #(
    parameter int NUM_MST = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [NUM_MST-1:0]     m_bus_req,
    output logic [NUM_MST-1:0]     m_bus_grant,
    input  logic [8*NUM_MST-1:0]   m_mst2slv_addr,
    input  logic [NUM_MST-1:0]     m_mst2slv_wr,
    input  logic [NUM_MST-1:0]     m_mst2slv_rd,
    input  logic [8*NUM_MST-1:0]   m_mst2slv_data,
    output logic [7:0]             m_slv2mst_data,

    output logic [7:0]             s_mst2slv_addr,
    output logic                   s_mst2slv_wr,
    output logic                   s_mst2slv_rd,
    output logic [7:0]             s_mst2slv_data,
    input  logic [7:0]             s_slv2mst_data,

    output logic                   bus_busy,
    output logic [2:0]             bus_owner
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam logic [2:0] LAST_RST = 3'(NUM_MST - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_MST-1:0] grant_q, grant_d;
    logic [2:0]         last_q,  last_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               owner_holds;
    logic               found;
    logic [IDX_W-1:0]   idx;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        grant_d     = '0;
        last_d      = last_q;
        found       = 1'b0;
        idx         = '0;
        owner_holds = |(grant_q & m_bus_req);

        if (owner_holds) begin
            // No preemption: the owner keeps the bus while it requests.
            grant_d = grant_q;
        end else begin
            // Search starts just after the previous owner, so a re-requesting
            // former owner is considered last.
            for (int k = 1; k <= NUM_MST; k++) begin
                // NOTE: blocking '=' in combinational logic; the loop relies
                // on 'found' updating immediately within the same pass.
                idx = IDX_W'((int'(last_q) + k) % NUM_MST);
                if (!found && m_bus_req[idx]) begin
                    found        = 1'b1;
                    grant_d[idx] = 1'b1;
                    last_d       = 3'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking '<=' for all registered state, so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            grant_q <= '0;
            last_q  <= LAST_RST;   // master 0 wins the first search
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus multiplexer (AND-OR, all zero when no grant is active)
    // ------------------------------------------------------------------
    always_comb begin
        s_mst2slv_addr = '0;
        s_mst2slv_data = '0;
        s_mst2slv_wr   = 1'b0;
        s_mst2slv_rd   = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            s_mst2slv_addr = s_mst2slv_addr | (m_mst2slv_addr[i*8 +: 8] & {8{grant_q[i]}});
            s_mst2slv_data = s_mst2slv_data | (m_mst2slv_data[i*8 +: 8] & {8{grant_q[i]}});
            s_mst2slv_wr   = s_mst2slv_wr   | (m_mst2slv_wr[i] & grant_q[i]);
            s_mst2slv_rd   = s_mst2slv_rd   | (m_mst2slv_rd[i] & grant_q[i]);
        end
    end

    // Masters qualify the broadcast read data with their own grant.
    assign m_slv2mst_data = s_slv2mst_data;

    // ------------------------------------------------------------------
    // Status: grant is one-hot or zero, so OR-ing indices is a valid encoder.
    // ------------------------------------------------------------------
    always_comb begin
        bus_owner = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_q[i]) begin
                bus_owner = bus_owner | 3'(i);
            end
        end
    end

    assign bus_busy    = |grant_q;
    assign m_bus_grant = grant_q;

endmodule

// File: tb/tb_minirisc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_minirisc_bus_arbiter
//
// Directed testbench for minirisc_bus_arbiter with NUM_MST = 4. Each scenario
// is a task with its own inline comparisons against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_minirisc_bus_arbiter;

    localparam int NUM_MST = 4;

    logic                 clk;
    logic                 rst;
    logic [NUM_MST-1:0]   m_bus_req;
    logic [NUM_MST-1:0]   m_bus_grant;
    logic [8*NUM_MST-1:0] m_mst2slv_addr;
    logic [NUM_MST-1:0]   m_mst2slv_wr;
    logic [NUM_MST-1:0]   m_mst2slv_rd;
    logic [8*NUM_MST-1:0] m_mst2slv_data;
    logic [7:0]           m_slv2mst_data;
    logic [7:0]           s_mst2slv_addr;
    logic                 s_mst2slv_wr;
    logic                 s_mst2slv_rd;
    logic [7:0]           s_mst2slv_data;
    logic [7:0]           s_slv2mst_data;
    logic                 bus_busy;
    logic [2:0]           bus_owner;

    int tests;
    int fails;
    bit mon_en;

    minirisc_bus_arbiter #(.NUM_MST(NUM_MST)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_bus_req      (m_bus_req),
        .m_bus_grant    (m_bus_grant),
        .m_mst2slv_addr (m_mst2slv_addr),
        .m_mst2slv_wr   (m_mst2slv_wr),
        .m_mst2slv_rd   (m_mst2slv_rd),
        .m_mst2slv_data (m_mst2slv_data),
        .m_slv2mst_data (m_slv2mst_data),
        .s_mst2slv_addr (s_mst2slv_addr),
        .s_mst2slv_wr   (s_mst2slv_wr),
        .s_mst2slv_rd   (s_mst2slv_rd),
        .s_mst2slv_data (s_mst2slv_data),
        .s_slv2mst_data (s_slv2mst_data),
        .bus_busy       (bus_busy),
        .bus_owner      (bus_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant must be one-hot or zero on every cycle once reset has been seen.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (!$onehot0(m_bus_grant)) begin
                fails++;
                $display("FAIL onehot0: grant=%b is not one-hot or zero", m_bus_grant);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b0;
        m_bus_req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            step();
            mon_en = 1'b1;
            tests++;
            if (m_bus_grant !== 4'b0000 || bus_busy !== 1'b0 || bus_owner !== 3'd0) begin
                fails++;
                $display("FAIL reset_state: grant=%b busy=%b owner=%0d, want 0000/0/0",
                         m_bus_grant, bus_busy, bus_owner);
            end
            tests++;
            if (s_mst2slv_addr !== 8'h00 || s_mst2slv_data !== 8'h00 ||
                s_mst2slv_wr !== 1'b0 || s_mst2slv_rd !== 1'b0) begin
                fails++;
                $display("FAIL reset_slave_out: addr=%h data=%h wr=%b rd=%b, want all 0",
                         s_mst2slv_addr, s_mst2slv_data, s_mst2slv_wr, s_mst2slv_rd);
            end
        end
        rst = 1'b1;
        step();
        tests++;
        if (m_bus_grant !== 4'b0001 || bus_owner !== 3'd0 || bus_busy !== 1'b1) begin
            fails++;
            $display("FAIL first_grant: grant=%b owner=%0d busy=%b, want 0001/0/1",
                     m_bus_grant, bus_owner, bus_busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold();
        m_bus_req            = 4'b0101;
        m_mst2slv_addr[7:0]  = 8'h80;
        m_mst2slv_data[7:0]  = 8'h5A;
        m_mst2slv_wr[0]      = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (m_bus_grant !== 4'b0001 || s_mst2slv_addr !== 8'h80 ||
                s_mst2slv_data !== 8'h5A || s_mst2slv_wr !== 1'b1) begin
                fails++;
                $display("FAIL hold_cycle%0d: grant=%b addr=%h data=%h wr=%b, want 0001/80/5a/1",
                         c, m_bus_grant, s_mst2slv_addr, s_mst2slv_data, s_mst2slv_wr);
            end
            if (c < 9) step();
        end
        m_bus_req       = 4'b0100;
        m_mst2slv_wr[0] = 1'b0;
        step();
        tests++;
        if (m_bus_grant !== 4'b0100 || bus_owner !== 3'd2 || bus_busy !== 1'b1) begin
            fails++;
            $display("FAIL handover: grant=%b owner=%0d busy=%b, want 0100/2/1",
                     m_bus_grant, bus_owner, bus_busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] exp_g;
        // Restart from a clean pointer so master 0 is first.
        rst       = 1'b0;
        m_bus_req = 4'b0000;
        step();
        rst       = 1'b1;
        m_bus_req = 4'b1111;
        step();
        for (int n = 0; n < 6; n++) begin
            exp_g = 4'b0001 << exp_order[n];
            tests++;
            if (m_bus_grant !== exp_g || bus_owner !== 3'(exp_order[n])) begin
                fails++;
                $display("FAIL rr_turn%0d: grant=%b owner=%0d, want %b/%0d",
                         n, m_bus_grant, bus_owner, exp_g, exp_order[n]);
            end
            step();
            tests++;
            if (m_bus_grant !== exp_g) begin
                fails++;
                $display("FAIL rr_hold%0d: grant=%b, want %b", n, m_bus_grant, exp_g);
            end
            m_bus_req[exp_order[n]] = 1'b0;
            step();
            m_bus_req[exp_order[n]] = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_isolation();
        m_mst2slv_wr   = '0;
        m_mst2slv_rd   = '0;
        m_mst2slv_addr = '0;
        m_mst2slv_data = '0;
        rst       = 1'b0;
        m_bus_req = 4'b0000;
        step();
        rst       = 1'b1;
        m_bus_req = 4'b0010;
        step();
        m_bus_req              = 4'b1010;
        m_mst2slv_addr[15:8]   = 8'h10;
        m_mst2slv_rd[1]        = 1'b0;
        m_mst2slv_addr[31:24]  = 8'hFF;
        m_mst2slv_rd[3]        = 1'b1;
        #1;
        tests++;
        if (m_bus_grant !== 4'b0010 || s_mst2slv_rd !== 1'b0 || s_mst2slv_addr !== 8'h10) begin
            fails++;
            $display("FAIL isolation_owned: grant=%b rd=%b addr=%h, want 0010/0/10",
                     m_bus_grant, s_mst2slv_rd, s_mst2slv_addr);
        end
        m_bus_req = 4'b0000;
        step();
        tests++;
        if (m_bus_grant !== 4'b0000 || bus_busy !== 1'b0 || bus_owner !== 3'd0 ||
            s_mst2slv_addr !== 8'h00 || s_mst2slv_rd !== 1'b0 ||
            s_mst2slv_wr !== 1'b0 || s_mst2slv_data !== 8'h00) begin
            fails++;
            $display("FAIL isolation_idle: grant=%b busy=%b owner=%0d addr=%h rd=%b wr=%b data=%h, want all 0",
                     m_bus_grant, bus_busy, bus_owner, s_mst2slv_addr, s_mst2slv_rd,
                     s_mst2slv_wr, s_mst2slv_data);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_read_broadcast();
        s_slv2mst_data = 8'hC3;
        #1;
        tests++;
        if (m_slv2mst_data !== 8'hC3) begin
            fails++;
            $display("FAIL rdata_idle: got %h, want c3", m_slv2mst_data);
        end
        // Last owner was 1; a lone request from 2 is granted next edge.
        m_bus_req = 4'b0100;
        step();
        tests++;
        if (m_slv2mst_data !== 8'hC3 || m_bus_grant !== 4'b0100) begin
            fails++;
            $display("FAIL rdata_granted: data=%h grant=%b, want c3/0100",
                     m_slv2mst_data, m_bus_grant);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_transfer();
        tests++;
        if (bus_owner !== 3'd2) begin
            fails++;
            $display("FAIL midrst_pre: owner=%0d, want 2", bus_owner);
        end
        rst = 1'b0;
        step();
        tests++;
        if (m_bus_grant !== 4'b0000 || bus_busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_clear: grant=%b busy=%b, want 0000/0", m_bus_grant, bus_busy);
        end
        rst       = 1'b1;
        m_bus_req = 4'b0110;
        step();
        tests++;
        if (m_bus_grant !== 4'b0010 || bus_owner !== 3'd1) begin
            fails++;
            $display("FAIL midrst_restart: grant=%b owner=%0d, want 0010/1",
                     m_bus_grant, bus_owner);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        tests          = 0;
        fails          = 0;
        mon_en         = 1'b0;
        rst            = 1'b0;
        m_bus_req      = '0;
        m_mst2slv_addr = '0;
        m_mst2slv_wr   = '0;
        m_mst2slv_rd   = '0;
        m_mst2slv_data = '0;
        s_slv2mst_data = '0;

        test_reset();
        test_hold();
        test_round_robin();
        test_isolation();
        test_read_broadcast();
        test_reset_mid_transfer();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
